cachepool_boot_responder: RTL



---
 rtl/cachepool_pkg.sv | 33 +++
 rtl/cachepool_wake_pulse.sv | 37 +++
 rtl/cachepool_boot_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cachepool_pkg.sv
// Shared constants and types for the cachepool boot responder.
// Holds the register offsets, the register index enum and the AMO opcodes.
package cachepool_pkg;

  localparam int unsigned BootAddrOffset = 32'h00;
  localparam int unsigned WakeOffset     = 32'h08;
  localparam int unsigned WakeCntOffset  = 32'h10;
  localparam int unsigned WakeCntWidth   = 32;

  typedef enum logic [1:0] {
    RegBoot,
    RegWake,
    RegWakeCnt,
    RegNone
  } boot_reg_idx_e;

  // Same encoding as the reqrsp amo_op_e.
  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

endpackage

// File: rtl/cachepool_wake_pulse.sv
// Wake pulse generator: ORs trigger masks into a pending set and drives it
// on debug_req for PulseCycles cycles after the latest trigger.
// Ports: clk_i, rst_i, trigger, mask[NumCores], debug_req[NumCores].
module cachepool_wake_pulse #(
  parameter int unsigned NumCores    = 4,
  parameter int unsigned PulseCycles = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trigger,
  input  logic [NumCores-1:0] mask,
  output logic [NumCores-1:0] debug_req
);

  localparam int unsigned CntW = $clog2(PulseCycles + 1);

  logic [CntW-1:0]     cnt_q;
  logic [NumCores-1:0] pend_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else if (trigger) begin
      cnt_q  <= CntW'(PulseCycles);
      pend_q <= pend_q | mask;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        pend_q <= '0;
      end
    end
  end

  assign debug_req = (cnt_q != '0) ? pend_q : '0;

endmodule

// File: rtl/cachepool_boot_responder.sv
// Reqrsp responder holding the boot entry point, a WAKE trigger register
// and a WAKE_CNT counter. Ports: reqrsp q_*/p_* channel, boot_addr_o,
// debug_req_o. Optional auto-wake under CACHEPOOL_BOOT_AUTOWAKE_EN.
module cachepool_boot_responder
  import cachepool_pkg::*;
#(
  parameter int unsigned          AddrWidth       = 48,
  parameter int unsigned          DataWidth       = 64,
  parameter int unsigned          NumCores        = 4,
  parameter logic [AddrWidth-1:0] BaseAddr        = '0,
  parameter int unsigned          WakePulseCycles = 1,
  parameter int unsigned          AutoWakeDelay   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   q_addr_i,
  input  logic                   q_write_i,
  input  logic [DataWidth-1:0]   q_data_i,
  input  logic [DataWidth/8-1:0] q_strb_i,
  input  logic [3:0]             q_amo_i,
  input  logic                   q_valid_i,
  output logic                   q_ready_o,
  output logic [DataWidth-1:0]   p_data_o,
  output logic                   p_error_o,
  output logic                   p_valid_o,
  input  logic                   p_ready_i,
  output logic [DataWidth-1:0]   boot_addr_o,
  output logic [NumCores-1:0]    debug_req_o
);

  localparam int unsigned StrbW = DataWidth / 8;

  if (WakePulseCycles < 1 || AutoWakeDelay < 1 ||
      DataWidth < WakeCntWidth) begin : g_bad_cfg
    $error("cachepool_boot_responder: bad parameters");
  end

  logic [AddrWidth-1:0]    offset;
  boot_reg_idx_e           idx;
  logic                    accept;
  logic                    err;
  logic [DataWidth-1:0]    rdata;
  logic [DataWidth-1:0]    boot_q;
  logic [DataWidth-1:0]    boot_d;
  logic                    boot_we;
  logic [WakeCntWidth-1:0] wake_cnt_q;
  logic [NumCores-1:0]     wmask;
  logic                    man_trig;
  logic                    auto_fire;
  logic                    pulse_trig;
  logic [NumCores-1:0]     pulse_mask;

  // Modular subtraction: addresses below BaseAddr wrap far out of range.
  assign offset = q_addr_i - BaseAddr;

  always_comb begin
    idx = RegNone;
    unique case (1'b1)
      offset == AddrWidth'(BootAddrOffset): idx = RegBoot;
      offset == AddrWidth'(WakeOffset):     idx = RegWake;
      offset == AddrWidth'(WakeCntOffset):  idx = RegWakeCnt;
      default:                              idx = RegNone;
    endcase
  end

  assign q_ready_o = !p_valid_o || p_ready_i;
  assign accept    = q_valid_i && q_ready_o;
  assign err       = (idx == RegNone) || (q_amo_i != AMONone);

  always_comb begin
    rdata = '0;
    unique case (idx)
      RegBoot:    rdata = boot_q;
      RegWakeCnt: rdata = DataWidth'(wake_cnt_q);
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    boot_d = boot_q;
    for (int i = 0; i < StrbW; i++) begin
      if (q_strb_i[i]) begin
        boot_d[8*i +: 8] = q_data_i[8*i +: 8];
      end
    end
  end

  assign boot_we  = accept && !err && q_write_i && (idx == RegBoot);
  assign wmask    = q_data_i[NumCores-1:0];
  assign man_trig = accept && !err && q_write_i &&
                    (idx == RegWake) && (wmask != '0);

`ifdef CACHEPOOL_BOOT_AUTOWAKE_EN
  localparam int unsigned DlyW = $clog2(AutoWakeDelay + 1);

  logic [DlyW-1:0] dly_q;

  // Nonzero counter means armed; the wake fires on its last cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_q <= '0;
    end else if (boot_we) begin
      dly_q <= (boot_d != '0) ? DlyW'(AutoWakeDelay) : '0;
    end else if (dly_q != '0) begin
      dly_q <= dly_q - DlyW'(1);
    end
  end

  assign auto_fire = (dly_q == DlyW'(1));
`else
  assign auto_fire = 1'b0;
`endif

  assign pulse_trig = man_trig || auto_fire;
  assign pulse_mask = (man_trig ? wmask : '0) |
                      (auto_fire ? '1 : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boot_q     <= '0;
      wake_cnt_q <= '0;
      p_valid_o  <= 1'b0;
      p_data_o   <= '0;
      p_error_o  <= 1'b0;
    end else begin
      if (boot_we) begin
        boot_q <= boot_d;
      end
      if (pulse_trig) begin
        wake_cnt_q <= wake_cnt_q + 1'b1;
      end
      if (accept) begin
        p_valid_o <= 1'b1;
        p_error_o <= err;
        p_data_o  <= (err || q_write_i) ? '0 : rdata;
      end else if (p_ready_i) begin
        p_valid_o <= 1'b0;
      end
    end
  end

  assign boot_addr_o = boot_q;

  cachepool_wake_pulse #(
    .NumCores    (NumCores),
    .PulseCycles (WakePulseCycles)
  ) u_wake_pulse (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .trigger   (pulse_trig),
    .mask      (pulse_mask),
    .debug_req (debug_req_o)
  );

endmodule
